// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge: turns the core's inst/data SRAM-like request ports into a
// single AXI master with single-beat reads and writes.
//   - One shared AR register; data reads win over inst reads.
//   - At most one outstanding read per port, one outstanding write.
//   - Responses are steered by rid; B completes the data port's write.
//   - Data reads are held off while a write is in flight (RAW hazard).
// Build option: define BRIDGE_RAW_ADDR_CHECK_EN to block a data read only
// when it targets the same 32-bit word as the in-flight write.
//
// Handshake rule used on every AXI channel and on the SRAM side: a transfer
// happens on the rising edge where valid (req) and ready (addr_ok) are both 1;
// a raised valid is held with stable payload until that edge.
module sram_axi_bridge #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        resetn,
  // inst port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data port
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready,
  // debug: write-path FSM state
  output logic [2:0]  wr_state_dbg
);

  typedef enum logic [2:0] {
    WR_IDLE      = 3'd0,  // no write in flight
    WR_ADDR_DATA = 3'd1,  // AW and W both pending
    WR_ADDR      = 3'd2,  // W done, AW pending
    WR_DATA      = 3'd3,  // AW done, W pending
    WR_RESP      = 3'd4   // waiting for B
  } wr_state_e;

  wr_state_e   wr_state_q, wr_state_d;

  logic        ar_valid_q;
  logic [31:0] ar_addr_q;
  logic [3:0]  ar_id_q;
  logic [1:0]  ar_size_q;
  logic        inst_rd_out_q, data_rd_out_q;

  logic [31:0] aw_addr_q;
  logic [1:0]  aw_size_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;

  logic        inst_ok_q, data_ok_q;
  logic [31:0] inst_rdata_q, data_rdata_q;

  logic        aw_pend, w_pend, wr_busy;
  logic        data_rd_req, raw_block;
  logic        data_rd_accept, inst_rd_accept, data_wr_accept;
  logic        r_hs, r_inst, r_data, b_done;

  // Responses that no longer belong to a tracked request (e.g. issued before a
  // reset) are consumed but produce no data_ok.
  assign r_hs   = rvalid & rready;
  assign r_inst = r_hs & (rid == INST_ID) & inst_rd_out_q;
  assign r_data = r_hs & (rid == DATA_ID) & data_rd_out_q;
  assign b_done = bvalid & bready & (wr_state_q == WR_RESP);

  assign data_rd_req = data_sram_req & ~data_sram_wr;

  // RAW hazard: decide whether the pending write blocks the current data read
  always_comb begin
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    raw_block = wr_busy & (aw_addr_q[31:2] == data_sram_addr[31:2]);
`else
    raw_block = wr_busy;
`endif
  end

  // Acceptance: one shared AR slot, data read wins; inst takes it otherwise
  always_comb begin
    data_rd_accept = data_rd_req & ~ar_valid_q & ~data_rd_out_q & ~raw_block;
    inst_rd_accept = inst_sram_req & ~ar_valid_q & ~inst_rd_out_q & ~data_rd_accept;
    data_wr_accept = data_sram_req & data_sram_wr & (wr_state_q == WR_IDLE);
  end

  assign inst_sram_addr_ok = inst_rd_accept;
  assign data_sram_addr_ok = data_rd_accept | data_wr_accept;

  // AR register: load on acceptance, release on arready
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ar_valid_q <= 1'b0;
      ar_addr_q  <= 32'd0;
      ar_id_q    <= 4'd0;
      ar_size_q  <= 2'd0;
    end else if (data_rd_accept) begin
      ar_valid_q <= 1'b1;
      ar_addr_q  <= data_sram_addr;
      ar_id_q    <= DATA_ID;
      ar_size_q  <= data_sram_size;
    end else if (inst_rd_accept) begin
      ar_valid_q <= 1'b1;
      ar_addr_q  <= inst_sram_addr;
      ar_id_q    <= INST_ID;
      ar_size_q  <= inst_sram_size;
    end else if (arready) begin
      ar_valid_q <= 1'b0;
    end
  end

  // Per-port read-outstanding flags: set on accept, clear on matching R
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_rd_out_q <= 1'b0;
      data_rd_out_q <= 1'b0;
    end else begin
      if (inst_rd_accept)      inst_rd_out_q <= 1'b1;
      else if (r_inst)         inst_rd_out_q <= 1'b0;
      if (data_rd_accept)      data_rd_out_q <= 1'b1;
      else if (r_data)         data_rd_out_q <= 1'b0;
    end
  end

  // Write payload capture on acceptance
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_addr_q <= 32'd0;
      aw_size_q <= 2'd0;
      w_data_q  <= 32'd0;
      w_strb_q  <= 4'd0;
    end else if (data_wr_accept) begin
      aw_addr_q <= data_sram_addr;
      aw_size_q <= data_sram_size;
      w_data_q  <= data_sram_wdata;
      w_strb_q  <= data_sram_wstrb;
    end
  end

  // Write FSM state register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) wr_state_q <= WR_IDLE;
    else         wr_state_q <= wr_state_d;
  end

  // Write FSM next state: AW and W retire independently, then wait for B
  always_comb begin
    wr_state_d = wr_state_q;
    case (wr_state_q)
      WR_IDLE:      if (data_wr_accept) wr_state_d = WR_ADDR_DATA;
      WR_ADDR_DATA: begin
        case ({awready, wready})
          2'b11:   wr_state_d = WR_RESP;
          2'b10:   wr_state_d = WR_DATA;
          2'b01:   wr_state_d = WR_ADDR;
          default: wr_state_d = WR_ADDR_DATA;
        endcase
      end
      WR_ADDR:      if (awready) wr_state_d = WR_RESP;
      WR_DATA:      if (wready)  wr_state_d = WR_RESP;
      WR_RESP:      if (b_done)  wr_state_d = WR_IDLE;
      default:      wr_state_d = WR_IDLE;
    endcase
  end

  // Write FSM outputs
  always_comb begin
    aw_pend = (wr_state_q == WR_ADDR_DATA) | (wr_state_q == WR_ADDR);
    w_pend  = (wr_state_q == WR_ADDR_DATA) | (wr_state_q == WR_DATA);
    wr_busy = (wr_state_q != WR_IDLE);
  end

  // Response registers: one-cycle data_ok per port, read beats captured.
  // bready is dropped while a data read beat is present, so r_data and
  // b_done never coincide.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      inst_ok_q    <= 1'b0;
      data_ok_q    <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      inst_ok_q <= r_inst;
      data_ok_q <= r_data | b_done;
      if (r_inst) inst_rdata_q <= rdata;
      if (r_data) data_rdata_q <= rdata;
    end
  end

  assign inst_sram_data_ok = inst_ok_q;
  assign inst_sram_rdata   = inst_rdata_q;
  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = data_rdata_q;

  assign arid    = ar_id_q;
  assign araddr  = ar_addr_q;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, ar_size_q};
  assign arburst = 2'b01;
  assign arlock  = 2'd0;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign arvalid = ar_valid_q;

  assign rready  = 1'b1;

  assign awid    = DATA_ID;
  assign awaddr  = aw_addr_q;
  assign awlen   = 8'd0;
  assign awsize  = {1'b0, aw_size_q};
  assign awburst = 2'b01;
  assign awlock  = 2'd0;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign awvalid = aw_pend;

  assign wid     = DATA_ID;
  assign wdata   = w_data_q;
  assign wstrb   = w_strb_q;
  assign wlast   = 1'b1;
  assign wvalid  = w_pend;

  // A data read beat takes priority over a simultaneous B response
  assign bready  = ~(rvalid & (rid == DATA_ID));

  assign wr_state_dbg = wr_state_q;

  // Inputs with no function in this bridge
  logic unused_inputs;
  assign unused_inputs = &{1'b0, inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                           rresp, rlast, bid, bresp};

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge: drives the SRAM ports and plays the AXI
// slave by hand, checking every output against hand-computed values.
module tb_sram_axi_bridge;

  logic        clk, resetn;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [2:0]  wr_state_dbg;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_other_word;

  sram_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
    .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .wr_state_dbg(wr_state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // inputs change 1ns after the rising edge; outputs are checked 1ns later
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic ar_handshake(input string tag, input logic [31:0] addr, input logic [3:0] id);
    settle();
    check({tag, "_arvalid"}, arvalid, 1);
    check({tag, "_araddr"}, araddr, addr);
    check({tag, "_arid"}, arid, id);
    arready = 1'b1;
    tick();
    arready = 1'b0;
    settle();
    check({tag, "_arvalid_clr"}, arvalid, 0);
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
    rvalid = 1'b1; rid = id; rdata = d;
    tick();
    rvalid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0;
    inst_sram_req = 0; inst_sram_wr = 0; inst_sram_size = 2'd2;
    inst_sram_wstrb = 0; inst_sram_addr = 0; inst_sram_wdata = 0;
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
    data_sram_wstrb = 0; data_sram_addr = 0; data_sram_wdata = 0;
    arready = 0; rid = 0; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 0; bresp = 0; bvalid = 0;
`ifdef BRIDGE_RAW_ADDR_CHECK_EN
    exp_other_word = 32'd1;
`else
    exp_other_word = 32'd0;
`endif

    // reset state
    tick(); tick();
    settle();
    check("rst_arvalid", arvalid, 0);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_inst_data_ok", inst_sram_data_ok, 0);
    check("rst_data_data_ok", data_sram_data_ok, 0);
    check("rst_rready", rready, 1);
    check("rst_bready", bready, 1);
    tick();
    resetn = 1'b1;

    // inst read 0x1C000000, arready after 2 cycles
    tick();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0000;
    settle();
    check("s1_inst_addr_ok", inst_sram_addr_ok, 1);
    check("s1_data_addr_ok", data_sram_addr_ok, 0);
    tick();
    inst_sram_req = 0;
    settle();
    check("s1_arsize", arsize, 3'b010);
    check("s1_arlen", arlen, 0);
    check("s1_arburst", arburst, 2'b01);
    tick(); tick();
    ar_handshake("s1", 32'h1C00_0000, 4'd0);
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0004;
    settle();
    check("s1_inst_busy_block", inst_sram_addr_ok, 0);
    inst_sram_req = 0;
    r_beat(4'd0, 32'h0280_0C0C);
    settle();
    check("s1_inst_data_ok", inst_sram_data_ok, 1);
    check("s1_inst_rdata", inst_sram_rdata, 32'h0280_0C0C);
    check("s1_data_data_ok", data_sram_data_ok, 0);
    tick(); settle();
    check("s1_inst_data_ok_pulse", inst_sram_data_ok, 0);

    // inst and data read in the same cycle: data wins
    tick();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0008;
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_0100;
    settle();
    check("s2_data_addr_ok", data_sram_addr_ok, 1);
    check("s2_inst_addr_ok", inst_sram_addr_ok, 0);
    tick();
    data_sram_req = 0;
    settle();
    check("s2_inst_wait_ar", inst_sram_addr_ok, 0);
    ar_handshake("s2d", 32'h0000_0100, 4'd1);
    check("s2_inst_addr_ok_late", inst_sram_addr_ok, 1);
    tick();
    inst_sram_req = 0;
    ar_handshake("s2i", 32'h1C00_0008, 4'd0);
    r_beat(4'd1, 32'hCAFE_0001);
    settle();
    check("s2_data_data_ok", data_sram_data_ok, 1);
    check("s2_data_rdata", data_sram_rdata, 32'hCAFE_0001);
    check("s2_inst_quiet", inst_sram_data_ok, 0);
    r_beat(4'd0, 32'hCAFE_0000);
    settle();
    check("s2_inst_data_ok", inst_sram_data_ok, 1);
    check("s2_inst_rdata", inst_sram_rdata, 32'hCAFE_0000);
    check("s2_data_data_ok_pulse", data_sram_data_ok, 0);

    // write 0x1000, wstrb 0011, awready one cycle before wready
    tick();
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_1000;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'hA5A5_1234; data_sram_size = 2'd1;
    settle();
    check("s3_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0; data_sram_wr = 0; data_sram_size = 2'd2;
    settle();
    check("s3_awvalid", awvalid, 1);
    check("s3_wvalid", wvalid, 1);
    check("s3_awaddr", awaddr, 32'h0000_1000);
    check("s3_awsize", awsize, 3'b001);
    check("s3_awid", awid, 4'd1);
    check("s3_wid", wid, 4'd1);
    check("s3_wdata", wdata, 32'hA5A5_1234);
    check("s3_wstrb", wstrb, 4'b0011);
    check("s3_wlast", wlast, 1);
    awready = 1;
    tick();
    awready = 0; wready = 1;
    settle();
    check("s3_awvalid_drop", awvalid, 0);
    check("s3_wvalid_hold", wvalid, 1);
    tick();
    wready = 0;
    settle();
    check("s3_wvalid_drop", wvalid, 0);
    check("s3_no_early_ok", data_sram_data_ok, 0);
    bvalid = 1; bid = 4'd1;
    settle();
    check("s3_bready", bready, 1);
    tick();
    bvalid = 0;
    settle();
    check("s3_b_data_ok", data_sram_data_ok, 1);
    tick(); settle();
    check("s3_b_data_ok_pulse", data_sram_data_ok, 0);

    // RAW: write 0x1000 pending blocks a read of 0x1000 until B
    tick();
    data_sram_req = 1; data_sram_wr = 1; data_sram_addr = 32'h0000_1000;
    data_sram_wdata = 32'h0000_BEEF; data_sram_wstrb = 4'hF;
    settle();
    check("s4_wr_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_wr = 0;
    settle();
    check("s4_raw_same", data_sram_addr_ok, 0);
    data_sram_addr = 32'h0000_2000;
    settle();
    check("s4_raw_other_word", data_sram_addr_ok, exp_other_word);
    data_sram_addr = 32'h0000_1000;
    awready = 1; wready = 1;
    tick();
    awready = 0; wready = 0;
    settle();
    check("s4_aw_w_done", {awvalid, wvalid}, 2'b00);
    check("s4_raw_b_pending", data_sram_addr_ok, 0);
    bvalid = 1;
    settle();
    check("s4_raw_b_valid", data_sram_addr_ok, 0);
    tick();
    bvalid = 0;
    settle();
    check("s4_b_data_ok", data_sram_data_ok, 1);
    check("s4_read_released", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0;
    ar_handshake("s4", 32'h0000_1000, 4'd1);
    r_beat(4'd1, 32'hDEAD_BEEF);
    settle();
    check("s4_rd_data_ok", data_sram_data_ok, 1);
    check("s4_rd_rdata", data_sram_rdata, 32'hDEAD_BEEF);

    // simultaneous R(rid 1) and B: read first, then write
    tick();
    data_sram_req = 1; data_sram_wr = 0; data_sram_addr = 32'h0000_4000;
    settle();
    check("s5_rd_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_wr = 1; data_sram_addr = 32'h0000_3000; data_sram_wdata = 32'h5555_AAAA;
    settle();
    check("s5_wr_addr_ok", data_sram_addr_ok, 1);
    tick();
    data_sram_req = 0; data_sram_wr = 0;
    awready = 1; wready = 1;
    ar_handshake("s5", 32'h0000_4000, 4'd1);
    awready = 0; wready = 0;
    rvalid = 1; rid = 4'd1; rdata = 32'h1111_2222; bvalid = 1; bid = 4'd1;
    settle();
    check("s5_bready_low", bready, 0);
    check("s5_rready", rready, 1);
    tick();
    rvalid = 0;
    settle();
    check("s5_first_ok", data_sram_data_ok, 1);
    check("s5_first_rdata", data_sram_rdata, 32'h1111_2222);
    check("s5_bready_back", bready, 1);
    tick();
    bvalid = 0;
    settle();
    check("s5_second_ok", data_sram_data_ok, 1);
    tick(); settle();
    check("s5_ok_end", data_sram_data_ok, 0);

    // async reset while arvalid is high; stale R afterwards is ignored
    tick();
    inst_sram_req = 1; inst_sram_addr = 32'h1C00_0010;
    tick();
    inst_sram_req = 0;
    settle();
    check("s6_arvalid_set", arvalid, 1);
    #1 resetn = 1'b0;
    #1;
    check("s6_arvalid_async", arvalid, 0);
    tick(); tick();
    resetn = 1'b1;
    r_beat(4'd0, 32'h0BAD_0BAD);
    settle();
    check("s6_no_stale_ok", inst_sram_data_ok, 0);
    check("s6_no_stale_rdata", inst_sram_rdata, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
